// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, interrupt field base.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Lowest bit of the IM field in SR and of the IP field in Cause
  localparam int unsigned IRQ_BASE = 10;

  // Return address for a take: word-aligned PC, backed up to the branch when in a delay slot
  function automatic logic [31:0] take_epc(input logic [31:0] pc, input logic in_ds);
    return (pc & 32'hFFFF_FFFC) - (in_ds ? 32'd4 : 32'd0);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky match request cleared by a Compare write.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pend,
  output logic        pend_nxt
);

  logic wr_count;
  logic wr_compare;

  assign wr_count   = we && (wr_addr == CP0_COUNT);
  assign wr_compare = we && (wr_addr == CP0_COMPARE);

  // Next pend value; exported so the IP bit can track pend without an extra cycle of lag
  always_comb begin
    pend_nxt = pend;
    if (wr_compare)
      pend_nxt = 1'b0;
    else if (count == compare)
      pend_nxt = 1'b1;
  end

  // Free-running counter, compare register and pending flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      compare <= '1;
      pend    <= 1'b0;
    end else begin
      count <= wr_count ? wdata : count + 32'd1;
      if (wr_compare)
        compare <= wdata;
      pend <= pend_nxt;
    end
  end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 controller: SR/Cause/EPC/PRId, optional timer, exception/interrupt take and eret.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HWINT = 6,
  parameter bit          HAS_TIMER = 1'b1,
  parameter logic [31:0] PRID_VAL  = 32'h1234_5678
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [31:0]          pc,
  input  logic                 in_delay_slot,
  input  logic [4:0]           exc_code,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 eret,
  output logic                 take,
  output logic [31:0]          epc
);

  logic [NUM_HWINT-1:0] im;
  logic [NUM_HWINT-1:0] ip;
  logic                 exl;
  logic                 ie;
  logic                 bd;
  logic [4:0]           exccode;
  logic [31:0]          epc_q;

  logic [31:0]          count_v;
  logic [31:0]          compare_v;
  logic                 timer_pend;
  logic                 timer_pend_nxt;

  logic [NUM_HWINT-1:0] irq_vec;
  logic [NUM_HWINT-1:0] ip_nxt;
  logic                 int_req;
  logic                 exc_req;
  logic [5:0]           im6;
  logic [5:0]           ip6;

  if (HAS_TIMER) begin : g_timer
    cp0_timer u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (we),
      .wr_addr  (wr_addr),
      .wdata    (wdata),
      .count    (count_v),
      .compare  (compare_v),
      .pend     (timer_pend),
      .pend_nxt (timer_pend_nxt)
    );
  end else begin : g_no_timer
    assign count_v        = '0;
    assign compare_v      = '0;
    assign timer_pend     = 1'b0;
    assign timer_pend_nxt = 1'b0;
  end

  // Interrupt vector and next IP; the timer line's IP follows pend_nxt so IP and pend rise together
  always_comb begin
    irq_vec = hw_int;
    ip_nxt  = hw_int;
    if (HAS_TIMER) begin
      irq_vec[NUM_HWINT-1] = hw_int[NUM_HWINT-1] | timer_pend;
      ip_nxt[NUM_HWINT-1]  = hw_int[NUM_HWINT-1] | timer_pend_nxt;
    end
  end

  assign int_req = (|(irq_vec & im)) & ie & ~exl;
  assign exc_req = (exc_code != EXC_INT) & ~exl;
  assign take    = exc_req | int_req;
  assign epc     = epc_q;

  // mfc0 read mux; IM/IP bits beyond NUM_HWINT read as zero
  always_comb begin
    im6 = '0;
    ip6 = '0;
    im6[NUM_HWINT-1:0] = im;
    ip6[NUM_HWINT-1:0] = ip;
    case (rd_addr)
      CP0_SR:      rdata = {16'b0, im6, 8'b0, exl, ie};
      CP0_CAUSE:   rdata = {bd, 15'b0, ip6, 3'b0, exccode, 2'b0};
      CP0_EPC:     rdata = epc_q;
      CP0_PRID:    rdata = PRID_VAL;
      CP0_COUNT:   rdata = count_v;
      CP0_COMPARE: rdata = compare_v;
      default:     rdata = '0;
    endcase
  end

  // Register update: mtc0 first, then take (or eret) overrides EXL/BD/EPC/ExcCode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      im      <= '0;
      ip      <= '0;
      exl     <= 1'b0;
      ie      <= 1'b0;
      bd      <= 1'b0;
      exccode <= EXC_INT;
      epc_q   <= '0;
    end else begin
      ip <= ip_nxt;
      if (we && (wr_addr == CP0_SR)) begin
        im  <= wdata[IRQ_BASE +: NUM_HWINT];
        exl <= wdata[1];
        ie  <= wdata[0];
      end
      if (we && (wr_addr == CP0_EPC))
        epc_q <= wdata & 32'hFFFF_FFFC;
      if (take) begin
        exl     <= 1'b1;
        bd      <= in_delay_slot;
        epc_q   <= take_epc(pc, in_delay_slot);
        exccode <= exc_req ? exc_code : EXC_INT;
      end else if (eret) begin
        exl <= 1'b0;
        bd  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: default instance plus a 2-line, timerless instance.
module tb_cp0_ctrl;

  logic        clk;
  logic        reset_n;

  logic        we;
  logic [4:0]  rd_addr;
  logic [4:0]  wr_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        in_delay_slot;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        eret;
  logic        take;
  logic [31:0] epc;

  logic        b_we;
  logic [4:0]  b_rd_addr;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wdata;
  logic [31:0] b_rdata;
  logic [1:0]  b_hw_int;
  logic        b_take;
  logic [31:0] b_epc;

  int nchk = 0;
  int nerr = 0;

  cp0_ctrl u0 (
    .clk(clk), .reset_n(reset_n), .we(we), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wdata(wdata), .rdata(rdata), .pc(pc), .in_delay_slot(in_delay_slot),
    .exc_code(exc_code), .hw_int(hw_int), .eret(eret), .take(take), .epc(epc)
  );

  cp0_ctrl #(.NUM_HWINT(2), .HAS_TIMER(1'b0), .PRID_VAL(32'h1234_5678)) u1 (
    .clk(clk), .reset_n(reset_n), .we(b_we), .rd_addr(b_rd_addr), .wr_addr(b_wr_addr),
    .wdata(b_wdata), .rdata(b_rdata), .pc(32'h0000_2000), .in_delay_slot(1'b0),
    .exc_code(5'd0), .hw_int(b_hw_int), .eret(1'b0), .take(b_take), .epc(b_epc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic rdchk1(input string tag, input logic [4:0] a, input logic [31:0] exp);
    b_rd_addr = a;
    #1;
    chk(tag, b_rdata, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wr_addr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    b_we = 1'b1; b_wr_addr = a; b_wdata = d;
    step();
    b_we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    we = 1'b0; rd_addr = '0; wr_addr = '0; wdata = '0;
    pc = '0; in_delay_slot = 1'b0; exc_code = '0; hw_int = '0; eret = 1'b0;
    b_we = 1'b0; b_rd_addr = '0; b_wr_addr = '0; b_wdata = '0; b_hw_int = '0;
    #2;

    // Reset state
    rdchk("rst_sr", 5'd12, 32'h0);
    rdchk("rst_cause", 5'd13, 32'h0);
    rdchk("rst_epc", 5'd14, 32'h0);
    rdchk("rst_prid", 5'd15, 32'h1234_5678);
    chk("rst_take", 32'(take), 32'h0);
    chk("rst_epc_out", epc, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Reduced instance: no timer, only IM bits 10..11 exist
    rdchk1("b_count", 5'd9, 32'h0);
    rdchk1("b_compare", 5'd11, 32'h0);
    wr1(5'd12, 32'h0000_FC01);
    rdchk1("b_sr_mask", 5'd12, 32'h0000_0C01);
    b_hw_int = 2'b10;
    #1;
    chk("b_take_line1", 32'(b_take), 32'h1);
    b_hw_int = 2'b00;
    step();

    // Interrupt take on line 0
    wr(5'd12, 32'h0000_0401);
    hw_int = 6'd1; pc = 32'h0000_3008; in_delay_slot = 1'b0;
    #1;
    chk("int_take", 32'(take), 32'h1);
    step();
    chk("int_epc", epc, 32'h0000_3008);
    rdchk("int_cause", 5'd13, 32'h0000_0400);
    rdchk("int_sr", 5'd12, 32'h0000_0403);
    chk("int_blocked", 32'(take), 32'h0);
    hw_int = 6'd0; eret = 1'b1;
    step();
    eret = 1'b0;
    rdchk("eret_sr", 5'd12, 32'h0000_0401);

    // Exception in delay slot with a simultaneous enabled interrupt
    exc_code = 5'd12; in_delay_slot = 1'b1; pc = 32'h0000_3010; hw_int = 6'd1;
    #1;
    chk("exc_take", 32'(take), 32'h1);
    step();
    exc_code = 5'd0; hw_int = 6'd0;
    rdchk("exc_epc", 5'd14, 32'h0000_300C);
    rdchk("exc_cause", 5'd13, 32'h8000_0430);
    eret = 1'b1; in_delay_slot = 1'b0;
    step();
    eret = 1'b0;
    rdchk("exc_eret_sr", 5'd12, 32'h0000_0401);
    rdchk("exc_eret_cause", 5'd13, 32'h0000_0030);

    // Timer interrupt on line 5 (IM bit 15)
    wr(5'd11, 32'd5);
    wr(5'd12, 32'h0000_8001);
    wr(5'd9, 32'd0);
    pc = 32'h0000_4000;
    rdchk("tmr_count0", 5'd9, 32'd0);
    repeat (4) step();
    rdchk("tmr_count4", 5'd9, 32'd4);
    chk("tmr_take_c4", 32'(take), 32'h0);
    step();
    rdchk("tmr_count5", 5'd9, 32'd5);
    chk("tmr_take_c5", 32'(take), 32'h0);
    step();
    chk("tmr_take_c6", 32'(take), 32'h1);
    rdchk("tmr_cause_c6", 5'd13, 32'h0000_8030);
    step();
    chk("tmr_epc", epc, 32'h0000_4000);
    rdchk("tmr_cause_c7", 5'd13, 32'h0000_8000);
    wr(5'd11, 32'd100);
    rdchk("tmr_cleared", 5'd13, 32'h0000_0000);
    wr(5'd12, 32'h0);

    // EPC write alignment, then take vs mtc0 and take vs eret
    wr(5'd14, 32'h0000_1237);
    rdchk("epc_wr", 5'd14, 32'h0000_1234);
    wr(5'd12, 32'h0000_0401);
    hw_int = 6'd1; pc = 32'h0000_5004;
    we = 1'b1; wr_addr = 5'd14; wdata = 32'h0000_1234;
    #1;
    chk("ovr_take", 32'(take), 32'h1);
    step();
    we = 1'b0; hw_int = 6'd0;
    chk("ovr_epc", epc, 32'h0000_5004);
    wr(5'd12, 32'h0000_0401);
    hw_int = 6'd1; eret = 1'b1;
    #1;
    chk("eret_take", 32'(take), 32'h1);
    step();
    eret = 1'b0; hw_int = 6'd0;
    rdchk("eret_take_sr", 5'd12, 32'h0000_0403);

    // Reset in the middle of a handler
    reset_n = 1'b0;
    rdchk("midrst_sr", 5'd12, 32'h0);
    chk("midrst_epc", epc, 32'h0);
    rdchk("midrst_compare", 5'd11, 32'hFFFF_FFFF);
    rdchk("midrst_count", 5'd9, 32'h0);
    chk("midrst_take", 32'(take), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
